// File: rtl/regfile_2r1w.sv
// Parametrised register file: one write port, two registered read ports with per-entry written tracking.
// Optional macro REGFILE_BYPASS_EN forwards same-edge write data to a read of the same address.
module regfile_2r1w #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re0,
    input  logic [ADDR_W-1:0] raddr0,
    output logic [DATA_W-1:0] rdata0,
    output logic              rvalid0,
    output logic              uninit0,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid1,
    output logic              uninit1,
    output logic              wr_err,
    output logic              rd_err
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  written_q, written_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic              uninit0_q, uninit0_d, uninit1_q, uninit1_d;
    logic              wr_err_q, wr_err_d, rd_err_q, rd_err_d;

    logic w_ok, r0_ok, r1_ok;
    assign w_ok  = {1'b0, waddr}  < DEPTH_C;
    assign r0_ok = {1'b0, raddr0} < DEPTH_C;
    assign r1_ok = {1'b0, raddr1} < DEPTH_C;

    // Storage update: clr wins over a same-edge write and silences its error.
    always_comb begin
        mem_d     = mem_q;
        written_d = written_q;
        wr_err_d  = we && !clr && !w_ok;
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
            written_d = '0;
        end else if (we && w_ok) begin
            mem_d[waddr]     = wdata;
            written_d[waddr] = 1'b1;
        end
    end

    // rvalidN is a one-cycle strobe after each accepted read; rdataN/uninitN hold otherwise.
    always_comb begin
        rdata0_d  = rdata0_q;
        uninit0_d = uninit0_q;
        rvalid0_d = re0;
        if (re0) begin
            if (r0_ok) begin
                rdata0_d  = mem_q[raddr0];
                uninit0_d = ~written_q[raddr0];
`ifdef REGFILE_BYPASS_EN
                if (we && !clr && w_ok && (waddr == raddr0)) begin
                    rdata0_d  = wdata;
                    uninit0_d = 1'b0;
                end
`endif
            end else begin
                rdata0_d  = '0;
                uninit0_d = 1'b1;
            end
        end
    end

    always_comb begin
        rdata1_d  = rdata1_q;
        uninit1_d = uninit1_q;
        rvalid1_d = re1;
        if (re1) begin
            if (r1_ok) begin
                rdata1_d  = mem_q[raddr1];
                uninit1_d = ~written_q[raddr1];
`ifdef REGFILE_BYPASS_EN
                if (we && !clr && w_ok && (waddr == raddr1)) begin
                    rdata1_d  = wdata;
                    uninit1_d = 1'b0;
                end
`endif
            end else begin
                rdata1_d  = '0;
                uninit1_d = 1'b1;
            end
        end
    end

    assign rd_err_d = (re0 && !r0_ok) || (re1 && !r1_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            written_q <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            uninit0_q <= 1'b0;
            uninit1_q <= 1'b0;
            wr_err_q  <= 1'b0;
            rd_err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            written_q <= written_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            uninit0_q <= uninit0_d;
            uninit1_q <= uninit1_d;
            wr_err_q  <= wr_err_d;
            rd_err_q  <= rd_err_d;
        end
    end

    assign rdata0  = rdata0_q;
    assign rvalid0 = rvalid0_q;
    assign uninit0 = uninit0_q;
    assign rdata1  = rdata1_q;
    assign rvalid1 = rvalid1_q;
    assign uninit1 = uninit1_q;
    assign wr_err  = wr_err_q;
    assign rd_err  = rd_err_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w (DEPTH=6 to exercise a non-power-of-2 depth and out-of-range addresses).
// Expected values come from an array model of the entries; REGFILE_BYPASS_EN selects the forwarding rule.
module tb_regfile_2r1w;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 6;
    localparam int ADDR_W = 3;

    logic              clk, rst, clr, we, re0, re1;
    logic [ADDR_W-1:0] waddr, raddr0, raddr1;
    logic [DATA_W-1:0] wdata, rdata0, rdata1;
    logic              rvalid0, rvalid1, uninit0, uninit1, wr_err, rd_err;

    regfile_2r1w #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .re0(re0), .raddr0(raddr0), .rdata0(rdata0), .rvalid0(rvalid0), .uninit0(uninit0),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1), .rvalid1(rvalid1), .uninit1(uninit1),
        .wr_err(wr_err), .rd_err(rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: entry contents and whether each entry has been written.
    logic [DATA_W-1:0] m_mem [DEPTH];
    bit                m_wr  [DEPTH];
    logic [DATA_W-1:0] exp_rdata0, exp_rdata1;
    logic              exp_uninit0, exp_uninit1, exp_rvalid0, exp_rvalid1, exp_wr_err, exp_rd_err;
    logic [DATA_W-1:0] exp_q[$];

    task automatic reset_model();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_wr[i]  = 1'b0;
        end
        exp_rdata0 = '0; exp_rdata1 = '0;
        exp_uninit0 = 1'b0; exp_uninit1 = 1'b0;
        exp_rvalid0 = 1'b0; exp_rvalid1 = 1'b0;
        exp_wr_err = 1'b0; exp_rd_err = 1'b0;
        exp_q.delete();
    endtask

    task automatic read_model(input int ra, input bit c, input bit w, input int wa, input int wd,
                              output logic [DATA_W-1:0] d, output logic u);
        if (ra >= DEPTH) begin
            d = '0;
            u = 1'b1;
        end else begin
            d = m_mem[ra];
            u = !m_wr[ra];
`ifdef REGFILE_BYPASS_EN
            if (w && !c && wa < DEPTH && wa == ra) begin
                d = DATA_W'(wd);
                u = 1'b0;
            end
`endif
        end
    endtask

    // Drive one cycle of inputs, predict outputs, advance past the edge.
    task automatic step(input bit c, input bit w, input int wa, input int wd,
                        input bit r0, input int ra0, input bit r1, input int ra1);
        clr = c; we = w; waddr = ADDR_W'(wa); wdata = DATA_W'(wd);
        re0 = r0; raddr0 = ADDR_W'(ra0); re1 = r1; raddr1 = ADDR_W'(ra1);
        exp_rvalid0 = r0;
        exp_rvalid1 = r1;
        exp_wr_err  = w && !c && wa >= DEPTH;
        exp_rd_err  = (r0 && ra0 >= DEPTH) || (r1 && ra1 >= DEPTH);
        if (r0) begin
            read_model(ra0, c, w, wa, wd, exp_rdata0, exp_uninit0);
            exp_q.push_back(exp_rdata0);
        end
        if (r1) read_model(ra1, c, w, wa, wd, exp_rdata1, exp_uninit1);
        if (c) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i] = '0;
                m_wr[i]  = 1'b0;
            end
        end else if (w && wa < DEPTH) begin
            m_mem[wa] = DATA_W'(wd);
            m_wr[wa]  = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 0; we = 0; waddr = '0; wdata = '0;
        re0 = 0; raddr0 = '0; re1 = 0; raddr1 = '0;
        reset_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({rdata0, rvalid0, uninit0, rdata1, rvalid1, uninit1, wr_err, rd_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=0",
                     {rdata0, rvalid0, uninit0, rdata1, rvalid1, uninit1, wr_err, rd_err});
        end
        step(0, 0, 0, 0, 1, 0, 1, 7);
        checks++;
        if ({rdata0, uninit0, rvalid0} !== {4'h0, 1'b1, 1'b1}) begin
            errors++; $display("FAIL reset_read0 got=%h/%b/%b want=0/1/1", rdata0, uninit0, rvalid0);
        end
        checks++;
        if ({rdata1, uninit1, rvalid1, rd_err} !== {4'h0, 1'b1, 1'b1, 1'b1}) begin
            errors++; $display("FAIL reset_read1 got=%h/%b/%b err=%b want=0/1/1 err=1", rdata1, uninit1, rvalid1, rd_err);
        end
        idle();
        checks++;
        if ({rvalid0, rvalid1, rd_err, uninit0, uninit1} !== 5'b00011) begin
            errors++; $display("FAIL reset_idle got=%b want=00011", {rvalid0, rvalid1, rd_err, uninit0, uninit1});
        end
    endtask

    task automatic test_write_read();
        step(0, 1, 0, 'hA, 0, 0, 0, 0);
        step(0, 1, 3, 'h5, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 1, 3);
        checks++;
        if ({rdata0, uninit0, rvalid0} !== {4'hA, 1'b0, 1'b1}) begin
            errors++; $display("FAIL wr_read0 got=%h/%b/%b want=a/0/1", rdata0, uninit0, rvalid0);
        end
        checks++;
        if ({rdata1, uninit1, rvalid1} !== {4'h5, 1'b0, 1'b1}) begin
            errors++; $display("FAIL wr_read1 got=%h/%b/%b want=5/0/1", rdata1, uninit1, rvalid1);
        end
        idle();
        checks++;
        if ({rdata0, rdata1, rvalid0, rvalid1} !== {4'hA, 4'h5, 1'b0, 1'b0}) begin
            errors++; $display("FAIL wr_hold got=%h %h %b%b want=a 5 00", rdata0, rdata1, rvalid0, rvalid1);
        end
    endtask

    task automatic test_hazard();
        logic [DATA_W-1:0] want;
`ifdef REGFILE_BYPASS_EN
        want = 4'hC;
`else
        want = 4'h5;
`endif
        step(0, 1, 3, 'hC, 1, 3, 0, 0);
        checks++;
        if ({rdata0, uninit0} !== {want, 1'b0}) begin
            errors++; $display("FAIL hazard_same_edge got=%h/%b want=%h/0", rdata0, uninit0, want);
        end
        step(0, 0, 0, 0, 1, 3, 1, 3);
        checks++;
        if ({rdata0, rdata1} !== {4'hC, 4'hC}) begin
            errors++; $display("FAIL hazard_next got=%h %h want=c c", rdata0, rdata1);
        end
    endtask

    task automatic test_clear();
        step(0, 1, 2, 'h9, 0, 0, 0, 0);
        step(1, 1, 2, 'hF, 1, 3, 0, 0);
        checks++;
        if ({rdata0, uninit0, wr_err} !== {4'hC, 1'b0, 1'b0}) begin
            errors++; $display("FAIL clear_same_edge got=%h/%b err=%b want=c/0 err=0", rdata0, uninit0, wr_err);
        end
        step(0, 0, 0, 0, 1, 2, 1, 0);
        checks++;
        if ({rdata0, uninit0, rdata1, uninit1, wr_err} !== {4'h0, 1'b1, 4'h0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL clear_after got=%h/%b %h/%b err=%b want=0/1 0/1 err=0",
                               rdata0, uninit0, rdata1, uninit1, wr_err);
        end
    endtask

    task automatic test_out_of_range();
        step(0, 1, 1, 'h6, 0, 0, 0, 0);
        step(0, 1, 6, 'h7, 0, 0, 0, 0);
        checks++;
        if (wr_err !== 1'b1) begin
            errors++; $display("FAIL oor_wr_err got=%b want=1", wr_err);
        end
        step(0, 0, 0, 0, 1, 1, 1, 7);
        checks++;
        if ({rdata0, uninit0, rdata1, uninit1, rd_err, wr_err} !== {4'h6, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0}) begin
            errors++; $display("FAIL oor_read got=%h/%b %h/%b rd_err=%b wr_err=%b want=6/0 0/1 1 0",
                               rdata0, uninit0, rdata1, uninit1, rd_err, wr_err);
        end
        step(0, 0, 0, 0, 1, 6, 1, 0);
        checks++;
        if ({rdata0, uninit0, rd_err, uninit1} !== {4'h0, 1'b1, 1'b1, 1'b1}) begin
            errors++; $display("FAIL oor_port0 got=%h/%b rd_err=%b uninit1=%b want=0/1 1 1",
                               rdata0, uninit0, rd_err, uninit1);
        end
        idle();
        checks++;
        if ({wr_err, rd_err} !== 2'b00) begin
            errors++; $display("FAIL oor_pulse got=%b want=00", {wr_err, rd_err});
        end
    endtask

    task automatic test_async_reset();
        step(0, 1, 4, 'hB, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 4, 0, 0);
        checks++;
        if ({rdata0, rvalid0} !== {4'hB, 1'b1}) begin
            errors++; $display("FAIL areset_pre got=%h/%b want=b/1", rdata0, rvalid0);
        end
        we = 1; waddr = 3'd5; wdata = 4'h3; re0 = 1; raddr0 = 3'd4;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({rdata0, rvalid0, uninit0, rdata1, rvalid1, uninit1, wr_err, rd_err} !== '0) begin
            errors++; $display("FAIL areset_immediate got=%b want=0",
                               {rdata0, rvalid0, uninit0, rdata1, rvalid1, uninit1, wr_err, rd_err});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        reset_model();
        step(0, 0, 0, 0, 1, 4, 1, 5);
        checks++;
        if ({rdata0, uninit0, rdata1, uninit1} !== {4'h0, 1'b1, 4'h0, 1'b1}) begin
            errors++; $display("FAIL areset_after got=%h/%b %h/%b want=0/1 0/1", rdata0, uninit0, rdata1, uninit1);
        end
    endtask

    task automatic test_random();
        exp_q.delete();
        for (int n = 0; n < 300; n++) begin
            step($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                 $urandom_range(0, 15), $urandom_range(0, 2) != 0, $urandom_range(0, 7),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 7));
            checks++;
            if (rvalid0 !== exp_rvalid0) begin
                errors++; $display("FAIL rnd_rvalid0 cyc=%0d got=%b want=%b", n, rvalid0, exp_rvalid0);
            end
            if (rvalid0 === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd_rdata0 cyc=%0d got=%h want=none", n, rdata0);
                end else begin
                    logic [DATA_W-1:0] e;
                    e = exp_q.pop_front();
                    if (rdata0 !== e) begin
                        errors++; $display("FAIL rnd_rdata0 cyc=%0d got=%h want=%h", n, rdata0, e);
                    end
                end
            end
            checks++;
            if ({rdata0, uninit0} !== {exp_rdata0, exp_uninit0}) begin
                errors++; $display("FAIL rnd_port0 cyc=%0d got=%h/%b want=%h/%b", n, rdata0, uninit0, exp_rdata0, exp_uninit0);
            end
            checks++;
            if ({rdata1, uninit1, rvalid1} !== {exp_rdata1, exp_uninit1, exp_rvalid1}) begin
                errors++; $display("FAIL rnd_port1 cyc=%0d got=%h/%b/%b want=%h/%b/%b", n,
                                   rdata1, uninit1, rvalid1, exp_rdata1, exp_uninit1, exp_rvalid1);
            end
            checks++;
            if ({wr_err, rd_err} !== {exp_wr_err, exp_rd_err}) begin
                errors++; $display("FAIL rnd_err cyc=%0d got=%b%b want=%b%b", n, wr_err, rd_err, exp_wr_err, exp_rd_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_hazard();
        test_clear();
        test_out_of_range();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Parametrised register file: one write port, two independent read ports with registered outputs.
- Successor to the team's fixed 8x4 single-port register file. Adds width/depth parameters, asynchronous reset, synchronous bulk clear and per-entry written tracking.
- Adds out-of-range address detection and read-valid strobes.
- Used as scratch/operand storage for small datapaths, e.g. two operand reads per cycle for an ALU.

Parameters:
- DATA_W, 4, data width in bits (>=1)
- DEPTH, 8, number of entries (>=2; need not be a power of 2)
- ADDR_W, 3, address width; must satisfy 2**ADDR_W >= DEPTH

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- clr  in  1  synchronous clear of all entries
- we  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- re0  in  1  read enable, port 0
- raddr0  in  ADDR_W  read address, port 0
- rdata0  out  DATA_W  registered read data, port 0
- rvalid0  out  1  one-cycle strobe: rdata0 updated
- uninit0  out  1  qualifies rdata0: entry never written since reset/clr
- re1  in  1  read enable, port 1
- raddr1  in  ADDR_W  read address, port 1
- rdata1  out  DATA_W  registered read data, port 1
- rvalid1  out  1  one-cycle strobe: rdata1 updated
- uninit1  out  1  qualifies rdata1
- wr_err  out  1  one-cycle pulse: write address out of range
- rd_err  out  1  one-cycle pulse: out-of-range read on either port

Behaviour:
- Reset (async, rst=1): all entries=0, all written bits=0. rdata0=rdata1=0, rvalid0=rvalid1=0, uninit0=uninit1=0, wr_err=rd_err=0. Takes effect immediately, mid-operation included. No write or read completes on an edge where rst=1.
- Write: on rising edge with we=1, clr=0, waddr<DEPTH: entry[waddr]<=wdata, written[waddr]<=1. Visible to reads issued on the next edge or later.
- Write with waddr>=DEPTH: no storage change; wr_err=1 for exactly the following cycle.
- Clear: on rising edge with clr=1: all entries<=0, all written<=0. clr has priority over a same-cycle write; that write is dropped, wr_err stays 0.
- Read latency is 1 cycle. Rising edge with reN=1 samples raddrN; after that edge rdataN=entry contents, uninitN=~written[raddrN], rvalidN=1 for one cycle.
- With reN=0: rvalidN=0, rdataN and uninitN hold their last values.
- Read with raddrN>=DEPTH: rdataN<=0, uninitN<=1, rvalidN=1, rd_err=1 for one cycle. rd_err is the OR of both ports.
- Both ports may read the same address in the same cycle; both return identical data.
- Read and write to the same address on the same edge: the read returns the pre-write contents (see Optional Feature).
- Read and clr on the same edge: the read returns the pre-clear contents and written state.
- No back-pressure; a read or write is accepted every cycle.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- When defined: same-edge read and in-range write to the same address (clr=0) forwards wdata to that port's rdataN with uninitN=0. Applies to each port independently.
- When defined, clr on the same edge still suppresses forwarding; the read returns the pre-clear contents.
- When undefined: read-before-write; the read returns the old contents.

Test Plan:
- Reset and idle: rst=1 for 2 cycles, then release -> all outputs 0. Read addr 0 and addr 7 -> rdata=0, uninit=1, rvalid pulses 1 cycle.
- Write 4'hA@0 and 4'h5@3; next cycle re0 addr0, re1 addr3 -> rdata0=4'hA, rdata1=4'h5, uninit0=uninit1=0, both rvalid=1 for one cycle. Following idle cycle: rvalid=0, data held.
- Same-edge hazard: entry3=4'h5; write 4'hC@3 while re0 reads addr3 -> rdata0=4'h5 without REGFILE_BYPASS_EN, 4'hC with it. A read of addr3 next cycle -> 4'hC in both builds.
- Clear priority: entries hold data; assert clr together with we=1, wdata=4'hF@2 -> next reads of addr2 and addr0 return 0 with uninit=1; wr_err=0.
- Out of range, DEPTH=6, ADDR_W=3: write 4'h7@6 -> wr_err pulse, no entry changes. Read addr7 on port1 -> rdata1=0, uninit1=1, rd_err pulse. Port0 read of addr1 in the same cycle is unaffected.
- Async reset mid-operation: assert rst between edges while we=1 and re0=1 are active -> outputs go to 0 immediately, before the next edge. Subsequent reads return 0 with uninit=1.
